// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC serial readout stage.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    OUTPUT = 2'd2
  } readout_state_e;

  localparam int AXIS_DATA_WIDTH = 32;

  function automatic int bits_per_lane(input int data_width, input int lanes);
    return data_width / lanes;
  endfunction

endpackage

// File: rtl/adc_sck_gen.sv
// ADC serial clock generator: SCK_DIV clk cycles per half-period, BPL full periods
// per readout, with a strobe on every falling sck edge and done after the last one.
module adc_sck_gen #(
  parameter int SCK_DIV = 2,
  parameter int BPL     = 6
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic enable,
  output logic sck,
  output logic strobe,
  output logic done
);

  localparam int DIV_W  = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int HALF_W = $clog2(2 * BPL + 1);
  localparam logic [DIV_W-1:0]  DIV_RELOAD  = DIV_W'(SCK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_RELOAD = HALF_W'(2 * BPL - 1);

  logic              sck_q, sck_d;
  logic              done_q, done_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic              tick;

  // half_q counts sck toggles still owed; sck starts high, so the final toggle is a fall
  assign tick   = enable && !done_q && (half_q != '0) && (div_q == '0);
  assign strobe = tick && sck_q;
  assign sck    = sck_q;
  assign done   = done_q;

  always_comb begin
    sck_d  = sck_q;
    done_d = done_q;
    div_d  = div_q;
    half_d = half_q;
    if (start) begin
      sck_d  = 1'b1;
      done_d = 1'b0;
      div_d  = DIV_RELOAD;
      half_d = HALF_RELOAD;
    end else if (!enable) begin
      sck_d  = 1'b0;
      done_d = 1'b0;
      div_d  = '0;
      half_d = '0;
    end else if (tick) begin
      sck_d  = !sck_q;
      div_d  = DIV_RELOAD;
      half_d = half_q - HALF_W'(1);
      if (half_q == HALF_W'(1)) done_d = 1'b1;
    end else if (!done_q && (half_q != '0)) begin
      div_d = div_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sck_q  <= 1'b0;
      done_q <= 1'b0;
      div_q  <= '0;
      half_q <= '0;
    end else begin
      sck_q  <= sck_d;
      done_q <= done_d;
      div_q  <= div_d;
      half_q <= half_d;
    end
  end

endmodule

// File: rtl/adc_readout.sv
// ADC serial readout: shifts one multi-lane sample per trigger and presents it as a
// sign-extended AXI-Stream beat, grouped into packets of packet_len samples.
//
// state  | meaning
// IDLE   | waiting for trigger, ready=1
// SHIFT  | sck running, lanes shifted in on each sck fall
// OUTPUT | beat held on m_axis until handshake
module adc_readout
  import adc_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int LANES      = 4,
  parameter int SCK_DIV    = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       trigger,
  input  logic                       clear,
  input  logic [31:0]                packet_len,
  output logic                       sck,
  input  logic [LANES-1:0]           sdo,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       ready,
  output logic                       last,
  output logic                       overrun
);

  localparam int BPL = bits_per_lane(DATA_WIDTH, LANES);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_SHIFT  = SHIFT;
  localparam logic [1:0] S_OUTPUT = OUTPUT;

  if (DATA_WIDTH % LANES != 0) begin : g_bad_lanes
    $fatal(1, "adc_readout: DATA_WIDTH must be a multiple of LANES");
  end
  if (DATA_WIDTH > AXIS_DATA_WIDTH || DATA_WIDTH < 1) begin : g_bad_width
    $fatal(1, "adc_readout: DATA_WIDTH must be 1..32");
  end
  if (SCK_DIV < 1) begin : g_bad_div
    $fatal(1, "adc_readout: SCK_DIV must be >= 1");
  end

  logic [1:0]                 state_q, state_d;
  logic [DATA_WIDTH-1:0]      shift_q, shift_d;
  logic [AXIS_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                       tvalid_q, tvalid_d;
  logic [31:0]                cnt_q, cnt_d;
  logic [31:0]                len_q, len_d;
  logic                       overrun_q, overrun_d;
  logic [BPL:0]               lane_tmp;
  logic                       accept, handshake, strobe, done;

  assign ready         = (state_q == S_IDLE) && !tvalid_q;
  assign accept        = trigger && ready;
  assign handshake     = tvalid_q && m_axis_tready;
  // tlast is derived live from the counter so a clear re-evaluates a pending beat
  assign m_axis_tlast  = tvalid_q && (cnt_q == len_q - 32'd1);
  assign last          = handshake && m_axis_tlast;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign overrun       = overrun_q;

  adc_sck_gen #(
    .SCK_DIV (SCK_DIV),
    .BPL     (BPL)
  ) u_sck_gen (
    .clk    (clk),
    .resetn (resetn),
    .start  (accept),
    .enable (state_q == S_SHIFT),
    .sck    (sck),
    .strobe (strobe),
    .done   (done)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    overrun_d = overrun_q;
    lane_tmp  = '0;

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (strobe) begin
          for (int k = 0; k < LANES; k++) begin
            lane_tmp = {shift_q[k*BPL +: BPL], sdo[k]};
            shift_d[k*BPL +: BPL] = lane_tmp[BPL-1:0];
          end
        end
        if (done) begin
          tdata_d  = AXIS_DATA_WIDTH'($signed(shift_q));
          tvalid_d = 1'b1;
          state_d  = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (handshake) begin
          tvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept && (cnt_q == 32'd0 || clear)) len_d = (packet_len == 32'd0) ? 32'd1 : packet_len;

    if (clear) cnt_d = 32'd0;
    else if (handshake) cnt_d = m_axis_tlast ? 32'd0 : cnt_q + 32'd1;

    if (clear) overrun_d = 1'b0;
    else if (trigger && !ready) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      cnt_q     <= 32'd0;
      len_q     <= 32'd1;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_adc_readout.sv
// Scoreboard bench for adc_readout: a packet/sign-extension model queues expected beats,
// a negedge monitor pops and compares them as the DUT hands them off.
module tb_adc_readout;

  localparam int DW  = 24;
  localparam int LN  = 4;
  localparam int BPL = DW / LN;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          trigger = 1'b0;
  logic          clear = 1'b0;
  logic [31:0]   packet_len = 32'd1;
  logic          sck;
  logic [LN-1:0] sdo;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic          ready;
  logic          last;
  logic          overrun;

  adc_readout #(.DATA_WIDTH(DW), .LANES(LN), .SCK_DIV(2)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .trigger       (trigger),
    .clear         (clear),
    .packet_len    (packet_len),
    .sck           (sck),
    .sdo           (sdo),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .ready         (ready),
    .last          (last),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_t;
  beat_t q[$];

  // ADC model: the sample's bit for the current sck period is presented on each lane
  logic [DW-1:0] cur_sample = '0;
  int            idx = 0;
  int            tr_mode = 0;
  int unsigned   m_cnt = 0;
  int unsigned   m_len = 1;

  always @(negedge sck) idx++;

  always_comb begin
    sdo = '0;
    for (int k = 0; k < LN; k++)
      if (idx >= 0 && idx < BPL) sdo[k] = cur_sample[k*BPL + BPL - 1 - idx];
  end

  always begin
    @(posedge clk); #1;
    case (tr_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] sext(input logic [DW-1:0] s);
    logic [31:0] v;
    v = {8'h00, s};
    if (s >= 24'h800000) v = v + 32'hFF00_0000;
    return v;
  endfunction

  task automatic push(input logic [DW-1:0] s);
    beat_t b;
    if (m_cnt == 0) m_len = (packet_len == 0) ? 1 : packet_len;
    b.d = sext(s);
    b.l = (m_cnt == m_len - 1);
    m_cnt = b.l ? 0 : m_cnt + 1;
    q.push_back(b);
  endtask

  task automatic send(input logic [DW-1:0] s, input bit push_it);
    int n = 0;
    while (!ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) chk("ready_wait", {31'b0, ready}, 32'd1);
    cur_sample = s;
    idx = 0;
    trigger = 1'b1;
    if (push_it) push(s);
    @(posedge clk); #1;
    trigger = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || m_axis_tvalid) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 1000) chk("drain_timeout", q.size(), 0);
  endtask

  beat_t       mb;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data = '0;

  always @(negedge clk) begin
    if (resetn) begin
      if (stall_prev) begin
        chk("stall_tdata", m_axis_tdata, stall_data);
        chk("stall_tvalid", {31'b0, m_axis_tvalid}, 32'd1);
      end
      if (m_axis_tvalid) chk("ready_while_valid", {31'b0, ready}, 32'd0);
      if (m_axis_tvalid && m_axis_tready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got tdata %h expected no beat", m_axis_tdata);
        end else begin
          mb = q.pop_front();
          chk("tdata", m_axis_tdata, mb.d);
          chk("tlast", {31'b0, m_axis_tlast}, {31'b0, mb.l});
          chk("last_pulse", {31'b0, last}, {31'b0, mb.l});
        end
      end else begin
        chk("last_idle", {31'b0, last}, 32'd0);
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_data = m_axis_tdata;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    int hi, first;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sck", {31'b0, sck}, 32'd0);
    chk("rst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    chk("rst_tlast", {31'b0, m_axis_tlast}, 32'd0);
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_last", {31'b0, last}, 32'd0);
    chk("rst_overrun", {31'b0, overrun}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", {31'b0, ready}, 32'd1);

    // single negative sample: latency and sck shape
    packet_len = 32'd1;
    send(24'h800001, 1);
    hi = 0;
    first = -1;
    for (int k = 0; k <= 30; k++) begin
      if (sck) hi++;
      if (m_axis_tvalid && first < 0) first = k;
      @(posedge clk); #1;
    end
    chk("t1_tvalid_latency", first, 23);
    chk("t1_sck_high_cycles", hi, 12);
    chk("t1_sck_falls", idx, BPL);
    chk("t1_tdata", m_axis_tdata, 32'hFF80_0001);
    drain();

    // back-pressure
    tr_mode = 2;
    send(24'h123456, 1);
    for (int n = 0; n < 100 && !m_axis_tvalid; n++) begin
      @(posedge clk); #1;
    end
    chk("t2_tvalid_up", {31'b0, m_axis_tvalid}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("t2_ready_stall", {31'b0, ready}, 32'd0);
    tr_mode = 0;
    drain();
    chk("t2_tdata", m_axis_tdata, 32'h0012_3456);

    // packet of 3 plus the first sample of the next packet
    packet_len = 32'd3;
    for (int i = 0; i < 4; i++) send(DW'($urandom), 1);
    drain();

    // trigger during SHIFT, then clear
    send(24'h5A5A5A, 1);
    repeat (4) @(posedge clk);
    #1;
    trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    chk("t4_overrun_set", {31'b0, overrun}, 32'd1);
    drain();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    m_cnt = 0;
    chk("t4_overrun_clr", {31'b0, overrun}, 32'd0);
    packet_len = 32'd2;
    send(24'h000777, 1);
    send(24'hFFFFFF, 1);
    drain();

    // reset mid-SHIFT
    send(24'h3C3C3C, 0);
    repeat (8) @(posedge clk);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("t5_sck_async_low", {31'b0, sck}, 32'd0);
    chk("t5_tvalid_low", {31'b0, m_axis_tvalid}, 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    m_cnt = 0;
    repeat (30) @(posedge clk);
    #1;
    chk("t5_no_beat", {31'b0, m_axis_tvalid}, 32'd0);
    chk("t5_ready", {31'b0, ready}, 32'd1);
    send(24'hA5C3E1, 1);
    drain();

    // packet_len 0 behaves as 1
    packet_len = 32'd0;
    tr_mode = 1;
    for (int i = 0; i < 4; i++) send(DW'($urandom), 1);
    drain();

    // random samples, lengths and back-pressure
    for (int i = 0; i < 40; i++) begin
      packet_len = 32'($urandom_range(0, 4));
      send(DW'($urandom), 1);
    end
    drain();
    tr_mode = 0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
